// File: rtl/perceptron_pkg.sv
// Shared types for the perceptron pipeline: adder width, adder request bundle and
// the result-register state used by the shared adder scheduler.
package perceptron_pkg;

  localparam int unsigned ADD_W = 16;

  typedef struct packed {
    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
    logic             cin;
  } add_req_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } res_state_t;

endpackage

// File: rtl/adder_loprec16.sv
// Low-precision 16-bit adder. The low byte is approximated with a bitwise OR;
// the high byte is an exact add whose carry-in is guessed from bit 7 of both operands.
// Carry-in of the request is not used by this datapath.
import perceptron_pkg::*;

module adder_loprec16 (
  input  logic [ADD_W-1:0] a_i,
  input  logic [ADD_W-1:0] b_i,
  output logic [ADD_W-1:0] sum_o
);

  logic       carry_guess;
  logic [7:0] hi_sum;

  // Approximate low half, exact high half with a speculated carry.
  always_comb begin
    carry_guess = a_i[7] & b_i[7];
    hi_sum      = a_i[15:8] + b_i[15:8] + {7'd0, carry_guess};
    sum_o       = {hi_sum, a_i[7:0] | b_i[7:0]};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches req_i starting at ptr_i and wrapping modulo NUM_REQ.
// Produces a one-hot grant plus the granted index; NUM_REQ need not be a power of two.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               valid_o
);

  // First requester at or after ptr_i (circularly) wins.
  always_comb begin
    int unsigned j;
    logic        found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = ID_W'(j);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin scheduler sharing one 16-bit adder among NUM_REQ requesters.
// One request is accepted per cycle; the sum and requester index are registered and
// offered on a single valid/ready result port with no bubble between results.
// Build option: ADDER_SHARE_EXACT_EN selects the exact adder; otherwise adder_loprec16.
import perceptron_pkg::*;

module adder_share_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = ADD_W,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_cin,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_sum,
  output logic [ID_W-1:0]           res_id,
  output logic                      busy
);

  res_state_t          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   sum_q;
  logic [ID_W-1:0]     id_q;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic                can_load;
  logic                accept;
  add_req_t            op;
  logic [ADD_W-1:0]    add_sum;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .valid_o (grant_any)
  );

  // Handshake: the result register can take a new sum when empty or being drained.
  always_comb begin
    can_load  = (state_q == EMPTY) | res_ready;
    req_ready = grant & {NUM_REQ{~rst & can_load}};
    accept    = grant_any & ~rst & can_load;
  end

  // Operand mux feeding the single shared adder.
  always_comb begin
    op     = '0;
    op.a   = req_a[grant_idx*DATA_W +: DATA_W];
    op.b   = req_b[grant_idx*DATA_W +: DATA_W];
    op.cin = req_cin[grant_idx];
  end

`ifdef ADDER_SHARE_EXACT_EN
  // Exact add; carry out is dropped.
  always_comb begin
    add_sum = op.a + op.b + {{(ADD_W-1){1'b0}}, op.cin};
  end
`else
  logic unused_cin;
  assign unused_cin = op.cin;

  adder_loprec16 u_adder (
    .a_i   (op.a),
    .b_i   (op.b),
    .sum_o (add_sum)
  );
`endif

  // Result FSM and pointer next-state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept) begin
          state_d = FULL;
        end else if (res_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // State, pointer and result registers; a pending result is discarded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sum_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        sum_q <= add_sum;
        id_q  <= grant_idx;
      end
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_sum   = sum_q;
  assign res_id    = id_q;
  assign busy      = res_valid | (|req_valid);

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_adder_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*16-1:0] req_a;
  logic [NREQ*16-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_sum;
  logic [IDW-1:0]    res_id;
  logic              busy;

  int checks = 0;
  int errors = 0;

  adder_share_arb #(
    .NUM_REQ (NREQ),
    .DATA_W  (16),
    .ID_W    (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Golden sum for the selected build.
  function automatic logic [15:0] model_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
    int unsigned lo, hi, c;
`ifdef ADDER_SHARE_EXACT_EN
    return 16'((int'(a) + int'(b) + int'(cin)) % 65536);
`else
    lo = (a % 256) | (b % 256);
    c  = ((a / 128) % 2) * ((b / 128) % 2);
    hi = ((a / 256) + (b / 256) + c) % 256;
    return 16'(hi * 256 + lo);
`endif
  endfunction

  // Transaction-level model of the block, advanced once per cycle.
  logic          m_valid = 1'b0;
  logic [15:0]   m_sum   = '0;
  int            m_id    = 0;
  int            m_ptr   = 0;
  bit            chk_en  = 1'b0;

  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] exp_ready;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (g < 0 && req_valid[j]) g = j;
    end
    exp_ready = '0;
    if (g >= 0 && !rst && (!m_valid || res_ready)) exp_ready[g] = 1'b1;
    if (chk_en) begin
      chk("res_valid", 32'(res_valid), 32'(m_valid));
      chk("res_sum", 32'(res_sum), 32'(m_sum));
      chk("res_id", 32'(res_id), 32'(m_id));
      chk("busy", 32'(busy), 32'(m_valid | (|req_valid)));
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
    end
    if (rst) begin
      m_valid = 1'b0;
      m_sum   = '0;
      m_id    = 0;
      m_ptr   = 0;
      chk_en  = 1'b1;
    end else if (exp_ready != '0) begin
      m_sum   = model_sum(req_a[g*16 +: 16], req_b[g*16 +: 16], req_cin[g]);
      m_id    = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % NREQ;
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] exp2, exp5;
    logic [NREQ-1:0] acc;
`ifdef ADDER_SHARE_EXACT_EN
    exp2 = 16'h2234;
    exp5 = 16'h0000;
`else
    exp2 = 16'h21FF;
    exp5 = 16'hFFFF;
`endif
    // 1. Reset with every requester valid.
    rst = 1'b1;
    req_valid = '1;
    res_ready = 1'b1;
    req_cin = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*16 +: 16] = 16'(16'h1000 * i + 16'h0101);
      req_b[i*16 +: 16] = 16'(16'h0011 * (i + 1));
    end
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_sum", 32'(res_sum), 32'h0);
    chk("rst_res_id", 32'(res_id), 32'h0);
    next_cycle();

    // 2. Single request from requester 2.
    rst = 1'b0;
    req_valid = 4'b0100;
    req_a[32 +: 16] = 16'h1234;
    req_b[32 +: 16] = 16'h0FFF;
    req_cin[2] = 1'b1;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h4);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("single_valid", 32'(res_valid), 32'h1);
    chk("single_sum", 32'(res_sum), 32'(exp2));
    chk("single_id", 32'(res_id), 32'h2);
    next_cycle();

    // 3. Round-robin with all valid.
    do_reset();
    req_cin = '0;
    req_valid = '1;
    @(negedge clk);
    chk("rr_first_ready", 32'(req_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_id", 32'(res_id), 32'(k % NREQ));
      chk("rr_valid", 32'(res_valid), 32'h1);
    end

    // 4. Backpressure then drain-and-accept on the same edge.
    next_cycle();
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_id", 32'(res_id), 32'h1);
      chk("bp_sum", 32'(res_sum), 32'(model_sum(req_a[16 +: 16], req_b[16 +: 16], 1'b0)));
    end
    next_cycle();
    res_ready = 1'b1;
    @(negedge clk);
    chk("drain_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    chk("drain_valid", 32'(res_valid), 32'h1);
    chk("drain_id", 32'(res_id), 32'h2);
    next_cycle();

    // 5. Wrap / overflow.
    do_reset();
    req_valid = 4'b0001;
    req_a[0 +: 16] = 16'hFFFF;
    req_b[0 +: 16] = 16'h0001;
    req_cin[0] = 1'b0;
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("wrap_sum", 32'(res_sum), 32'(exp5));
    next_cycle();

    // 6. Low byte of the default datapath.
    req_valid = 4'b0010;
    req_a[16 +: 16] = 16'h00F0;
    req_b[16 +: 16] = 16'h000F;
    req_cin[1] = 1'b0;
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("lo_byte", 32'(res_sum[7:0]), 32'hFF);
    chk("lo_sum", 32'(res_sum), 32'h00FF);
    chk("lo_id", 32'(res_id), 32'h1);
    next_cycle();

    // 7. Reset while FULL.
    req_valid = '1;
    res_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("full_before_rst", 32'(res_valid), 32'h1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(res_valid), 32'h0);
    chk("rst_mid_grant", 32'(req_ready), 32'h1);
    next_cycle();

    // Randomized traffic; requesters hold valid and data until accepted.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      next_cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_a[i*16 +: 16] = 16'($urandom);
          req_b[i*16 +: 16] = 16'($urandom);
          req_cin[i] = 1'($urandom);
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    repeat (3) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
